// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the loader and the single
// instruction-memory port, with the arbiter as the slave side.
interface imem_port_arbiter_if #(
   parameter int SIZE = 32
);
   logic            f_req;
   logic [SIZE-1:0] f_addr;
   logic            f_gnt;
   logic            f_valid;
   logic [SIZE-1:0] f_data;
   logic            f_err;
   logic            l_req;
   logic [SIZE-1:0] l_addr;
   logic [SIZE-1:0] l_data;
   logic            l_gnt;
   logic            mem_wea;
   logic [SIZE-1:0] mem_addra;
   logic [SIZE-1:0] mem_dina;
   logic [SIZE-1:0] mem_douta;
   logic [SIZE-1:0] load_cnt;

   modport slave (
      input  f_req, f_addr, l_req, l_addr, l_data, mem_douta,
      output f_gnt, f_valid, f_data, f_err, l_gnt,
      output mem_wea, mem_addra, mem_dina, load_cnt
   );

   modport master (
      output f_req, f_addr, l_req, l_addr, l_data, mem_douta,
      input  f_gnt, f_valid, f_data, f_err, l_gnt,
      input  mem_wea, mem_addra, mem_dina, load_cnt
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (reads)
// and the program loader (writes), with bounded fetch starvation.
module imem_port_arbiter #(
   parameter int SIZE       = 32,
   parameter int MEM_SIZE   = 32,
   parameter int STARVE_MAX = 4
) (
   input logic                 clka,
   input logic                 rsta_n,
   imem_port_arbiter_if.slave  bus
);
   localparam int SW =
      (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SIZE-1:0] LIM = SIZE'(MEM_SIZE);
   localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, RD, WR} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            f_err_q, f_err_d;
   logic [SIZE-1:0] load_cnt_q, load_cnt_d;

   logic f_in, l_in;
   logic f_gnt, l_gnt;
   logic wr_ok, rd_ok;

   assign f_in  = bus.f_addr < LIM;
   assign l_in  = bus.l_addr < LIM;

   // Loader wins ties until the waiting fetch has seen STARVE_MAX losses.
   assign f_gnt = rsta_n & bus.f_req &
                  (~bus.l_req | (starve_q == SMAX));
   assign l_gnt = rsta_n & bus.l_req & ~f_gnt;
   assign wr_ok = l_gnt & l_in;
   assign rd_ok = f_gnt & f_in;

   always_comb begin
      state_d    = IDLE;
      starve_d   = '0;
      f_err_d    = 1'b0;
      load_cnt_d = load_cnt_q;
      unique case (1'b1)
         f_gnt: begin
            state_d = RD;
            f_err_d = ~f_in;
         end
         l_gnt: begin
            state_d = WR;
            if (bus.f_req) starve_d = starve_q + 1'b1;
            if (l_in) load_cnt_d = load_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         f_err_q    <= 1'b0;
         load_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         f_err_q    <= f_err_d;
         load_cnt_q <= load_cnt_d;
      end
   end

   assign bus.f_gnt     = f_gnt;
   assign bus.l_gnt     = l_gnt;
   assign bus.f_valid   = (state_q == RD);
   assign bus.f_err     = f_err_q;
   assign bus.f_data    = ((state_q == RD) && !f_err_q) ?
                          bus.mem_douta : '0;
   assign bus.mem_wea   = wr_ok;
   assign bus.mem_addra = wr_ok ? bus.l_addr :
                          rd_ok ? bus.f_addr : '0;
   assign bus.mem_dina  = wr_ok ? bus.l_data : '0;
   assign bus.load_cnt  = load_cnt_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed plus random checks of the imem port arbiter against
// a transaction-level model of grants, memory and read returns.
module tb_imem_port_arbiter;
   localparam int MS = 32;
   localparam int SM = 4;

   logic clka = 1'b0;
   logic rsta_n = 1'b0;
   always #5 clka = ~clka;

   imem_port_arbiter_if #(.SIZE(32)) bus ();

   imem_port_arbiter #(
      .SIZE(32), .MEM_SIZE(MS), .STARVE_MAX(SM)
   ) dut (
      .clka(clka), .rsta_n(rsta_n), .bus(bus)
   );

   function automatic logic [31:0] pat(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // Synchronous single-port RAM, 1-cycle read latency.
   logic [31:0] ram [MS];
   logic        ram_ok = 1'b0;
   always @(posedge clka) begin
      if (!ram_ok) begin
         for (int i = 0; i < MS; i++) ram[i] <= pat(i);
         ram_ok <= 1'b1;
      end else begin
         if (bus.mem_wea) ram[bus.mem_addra[4:0]] <= bus.mem_dina;
         bus.mem_douta <= ram[bus.mem_addra[4:0]];
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   int          starve;
   logic        pend_v, pend_e;
   logic [31:0] pend_d;
   logic [31:0] mem_m [MS];
   logic [31:0] lcnt;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      starve = 0;
      pend_v = 1'b0;
      pend_e = 1'b0;
      pend_d = '0;
      lcnt   = '0;
   endtask

   // One cycle: drive, check mid-cycle, advance the model, clock.
   task automatic step(input logic fr, input logic [31:0] fa,
                       input logic lr, input logic [31:0] la,
                       input logic [31:0] ld,
                       output logic gf, output logic gl);
      logic        ef, el, ew, fok, lok;
      logic [31:0] ea, ed;
      bus.f_req  = fr;
      bus.f_addr = fa;
      bus.l_req  = lr;
      bus.l_addr = la;
      bus.l_data = ld;
      @(negedge clka);
      fok = fa < MS;
      lok = la < MS;
      ef  = fr && (!lr || starve == SM);
      el  = lr && !ef;
      ew  = el && lok;
      ea  = ew ? la : (ef && fok) ? fa : 32'h0;
      ed  = ew ? ld : 32'h0;
      chk("f_gnt", 32'(bus.f_gnt), 32'(ef));
      chk("l_gnt", 32'(bus.l_gnt), 32'(el));
      chk("mem_wea", 32'(bus.mem_wea), 32'(ew));
      chk("mem_addra", bus.mem_addra, ea);
      chk("mem_dina", bus.mem_dina, ed);
      chk("f_valid", 32'(bus.f_valid), 32'(pend_v));
      chk("f_err", 32'(bus.f_err), 32'(pend_v && pend_e));
      chk("f_data", bus.f_data, pend_v ? pend_d : 32'h0);
      chk("load_cnt", bus.load_cnt, lcnt);
      pend_v = ef;
      pend_e = !fok;
      pend_d = (ef && fok) ? mem_m[fa[4:0]] : 32'h0;
      if (ew) begin
         mem_m[la[4:0]] = ld;
         lcnt = lcnt + 1;
      end
      if (ef || !fr) starve = 0;
      else if (el) starve++;
      gf = ef;
      gl = el;
      @(posedge clka);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_f_gnt"}, 32'(bus.f_gnt), 0);
      chk({tag, "_l_gnt"}, 32'(bus.l_gnt), 0);
      chk({tag, "_f_valid"}, 32'(bus.f_valid), 0);
      chk({tag, "_f_err"}, 32'(bus.f_err), 0);
      chk({tag, "_f_data"}, bus.f_data, 0);
      chk({tag, "_mem_wea"}, 32'(bus.mem_wea), 0);
      chk({tag, "_mem_addra"}, bus.mem_addra, 0);
      chk({tag, "_mem_dina"}, bus.mem_dina, 0);
      chk({tag, "_load_cnt"}, bus.load_cnt, 0);
   endtask

   initial begin
      logic        gf, gl, rf, rl;
      logic [31:0] rfa, rla, rld, lc0;
      int          lthr;
      for (int i = 0; i < MS; i++) mem_m[i] = pat(i);
      model_reset();
      bus.f_req  = 1'b1;
      bus.f_addr = 32'd2;
      bus.l_req  = 1'b1;
      bus.l_addr = 32'd4;
      bus.l_data = 32'hDEAD_BEEF;
      repeat (3) @(posedge clka);
      #1;
      chk_zero("rst");
      bus.f_req = 1'b0;
      bus.l_req = 1'b0;
      @(negedge clka);
      rsta_n = 1'b1;
      @(posedge clka);
      #1;

      // single fetch, then its return
      step(1, 1, 0, 0, 0, gf, gl);
      step(0, 0, 0, 0, 0, gf, gl);

      // starvation bound: L,L,L,L,F,L
      for (int i = 0; i < 6; i++) begin
         step(1, 32'(i), 1, 5, 32'(i) + 32'h55, gf, gl);
         chk("starve_seq", 32'(gl), (i == 4) ? 0 : 1);
      end
      step(0, 0, 0, 0, 0, gf, gl);

      // reset pulse the cycle after a fetch grant
      step(1, 9, 0, 0, 0, gf, gl);
      rsta_n = 1'b0;
      bus.f_req = 1'b1;
      bus.l_req = 1'b1;
      #1;
      chk_zero("rpulse");
      bus.f_req = 1'b0;
      bus.l_req = 1'b0;
      @(negedge clka);
      rsta_n = 1'b1;
      @(posedge clka);
      #1;
      model_reset();
      step(0, 0, 0, 0, 0, gf, gl);
      step(0, 0, 0, 0, 0, gf, gl);

      // write then read-after-write
      step(0, 0, 1, 3, 32'hA5A5_A5A5, gf, gl);
      step(1, 3, 0, 0, 0, gf, gl);
      step(0, 0, 0, 0, 0, gf, gl);
      chk("raw_load_cnt", bus.load_cnt, 1);

      // out-of-range fetch and write
      lc0 = bus.load_cnt;
      step(1, 32, 0, 0, 0, gf, gl);
      step(0, 0, 1, 40, 32'h1234_5678, gf, gl);
      chk("oor_gnt", 32'(gl), 1);
      step(0, 0, 0, 0, 0, gf, gl);
      chk("oor_load_cnt", bus.load_cnt, lc0);

      // back-to-back fetches 0,1,7
      step(1, 0, 0, 0, 0, gf, gl);
      step(1, 1, 0, 0, 0, gf, gl);
      step(1, 7, 0, 0, 0, gf, gl);
      step(0, 0, 0, 0, 0, gf, gl);
      step(0, 0, 0, 0, 0, gf, gl);

      // random traffic, requests held until granted
      rf = 1'b0; rl = 1'b0;
      rfa = '0; rla = '0; rld = '0;
      for (int i = 0; i < 400; i++) begin
         lthr = (i < 200) ? 7 : 3;
         if (!rf && $urandom_range(0, 3) != 0) begin
            rf  = 1'b1;
            rfa = $urandom_range(0, 39);
         end
         if (!rl && $urandom_range(0, 7) < lthr) begin
            rl  = 1'b1;
            rla = $urandom_range(0, 39);
            rld = $urandom;
         end
         step(rf, rfa, rl, rla, rld, gf, gl);
         if (gf) rf = 1'b0;
         if (gl) rl = 1'b0;
      end
      step(0, 0, 0, 0, 0, gf, gl);
      step(0, 0, 0, 0, 0, gf, gl);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
